// File: rtl/usb_ahb_pkg.sv
// Definitions shared by the AHB-Lite slave and the USB data path:
// hsize encodings, the default buffer depth and the transfer request type.
package usb_ahb_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int BUFFER_DEPTH = 64;

  // One arbitrated push or pop: valid flag and byte count (1, 2 or 4)
  typedef struct packed {
    logic       vld;
    logic [2:0] n;
  } xfer_t;

  function automatic logic [2:0] size_to_bytes(input logic [1:0] hsize);
    case (hsize)
      SIZE_BYTE: size_to_bytes = 3'd1;
      SIZE_HALF: size_to_bytes = 3'd2;
      SIZE_WORD: size_to_bytes = 3'd4;
      default:   size_to_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/data_buffer.sv
// Byte-wide circular buffer between the AHB slave (1/2/4-byte push/pop)
// and the USB TX/RX packet engines (single-byte push/pop).
module data_buffer
  import usb_ahb_pkg::*;
#(
  parameter int DEPTH = BUFFER_DEPTH
) (
  input  logic                     clk,
  input  logic                     nRst,
  input  logic                     store_tx_data,
  input  logic                     get_rx_data,
  input  logic [1:0]               data_size,
  input  logic [31:0]              tx_data,
  output logic [31:0]              rx_data,
  input  logic                     get_tx_packet_data,
  output logic [7:0]               tx_packet_data,
  input  logic                     store_rx_packet_data,
  input  logic [7:0]               rx_packet_data,
  input  logic                     clear,
  output logic [$clog2(DEPTH):0]   buffer_occupancy,
  output logic                     overflow_err,
  output logic                     underflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam logic [OW:0] L_DEPTH = (OW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [OW-1:0] r_occ;
  logic          r_ovf, r_unf;

  logic [2:0]    w_ahb_n;
  xfer_t         w_push, w_pop;
  logic          w_push_ahb;
  logic          w_rx_drop, w_tx_drop;
  logic          w_push_ok, w_pop_ok;
  logic [OW:0]   w_occ_x, w_push_n_x, w_pop_n_x;
  logic [7:0]    w_push_byte [4];

  assign w_ahb_n = size_to_bytes(data_size);

  // AHB requests win over the USB side; a size-11 AHB request is not a request
  always_comb begin
    w_push     = '0;
    w_push_ahb = 1'b0;
    w_rx_drop  = 1'b0;
    if (store_tx_data && w_ahb_n != 3'd0) begin
      w_push     = '{vld: 1'b1, n: w_ahb_n};
      w_push_ahb = 1'b1;
      w_rx_drop  = store_rx_packet_data;
    end else if (store_rx_packet_data) begin
      w_push = '{vld: 1'b1, n: 3'd1};
    end
  end

  always_comb begin
    w_pop     = '0;
    w_tx_drop = 1'b0;
    if (get_rx_data && w_ahb_n != 3'd0) begin
      w_pop     = '{vld: 1'b1, n: w_ahb_n};
      w_tx_drop = get_tx_packet_data;
    end else if (get_tx_packet_data) begin
      w_pop = '{vld: 1'b1, n: 3'd1};
    end
  end

  // Both acceptance checks look only at the pre-cycle occupancy
  assign w_occ_x    = {1'b0, r_occ};
  assign w_push_n_x = {{(OW-2){1'b0}}, w_push.n};
  assign w_pop_n_x  = {{(OW-2){1'b0}}, w_pop.n};
  assign w_push_ok  = w_push.vld && (w_occ_x + w_push_n_x <= L_DEPTH);
  assign w_pop_ok   = w_pop.vld && (w_pop_n_x <= w_occ_x);

  for (genvar k = 0; k < 4; k++) begin : g_byte
    assign w_push_byte[k] = w_push_ahb ? tx_data[8*k +: 8] : rx_packet_data;
    assign rx_data[8*k +: 8] = (r_occ > OW'(k)) ? r_mem[r_rptr + PW'(k)] : 8'h00;
  end

  assign tx_packet_data = (r_occ != '0) ? r_mem[r_rptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (!clear && w_push_ok) begin
      for (int k = 0; k < 4; k++) begin
        if (k < int'(w_push.n)) r_mem[r_wptr + PW'(k)] <= w_push_byte[k];
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else if (clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PW'(w_push.n);
      if (w_pop_ok)  r_rptr <= r_rptr + PW'(w_pop.n);
      r_occ <= r_occ + (w_push_ok ? OW'(w_push.n) : '0)
                     - (w_pop_ok  ? OW'(w_pop.n)  : '0);
      r_ovf <= w_rx_drop || (w_push.vld && !w_push_ok);
      r_unf <= w_tx_drop || (w_pop.vld && !w_pop_ok);
    end
  end

  assign buffer_occupancy = r_occ;
  assign overflow_err     = r_ovf;
  assign underflow_err    = r_unf;

endmodule

// File: doc/data_buffer.md
# data_buffer

Byte-wide circular data buffer between the AHB-Lite slave interface and the USB packet engines. It consumes the `storeTxData`/`getRxData` strobes and transfer size produced by the AHB state controller. Each AHB write pushes 1, 2 or 4 bytes of `hwdata`, and each AHB read pops 1, 2 or 4 bytes into `hrdata`. On the USB side it serves one byte at a time to the TX encoder and accepts one byte at a time from the RX decoder. It also reports its occupancy for the status registers.

## Interface
Parameters:
- `DEPTH`, 64: buffer capacity in bytes; power of two, minimum 4.

Ports:
- `clk` in 1: clock.
- `nRst` in 1: asynchronous, active-low reset.
- `store_tx_data` in 1: AHB write; valid in the AHB data phase, already delayed one cycle by the upstream controller.
- `get_rx_data` in 1: AHB read; valid in the data phase.
- `data_size` in 2: AHB hsize for the current data phase. Byte count = 1 for 00, 2 for 01, 4 for 10; 11 = no-op.
- `tx_data` in 32: hwdata.
- `rx_data` out 32: hrdata view of buffer head.
- `get_tx_packet_data` in 1: USB TX pops one byte.
- `tx_packet_data` out 8: byte at head.
- `store_rx_packet_data` in 1: USB RX pushes one byte.
- `rx_packet_data` in 8: byte to push.
- `clear` in 1: synchronous flush.
- `buffer_occupancy` out $clog2(DEPTH)+1: bytes currently held.
- `overflow_err` out 1: one-cycle pulse; a push was rejected.
- `underflow_err` out 1: one-cycle pulse; a pop was rejected.

## Operation
- **Storage and counters:**
  - Storage is `DEPTH` x 8 array.
  - `wptr` and `rptr` are $clog2(DEPTH) bits and wrap modulo `DEPTH`.
  - `occupancy` is a separate counter in the range 0..`DEPTH`.
- **Byte order:** little-endian. `tx_data[7:0]` is pushed first. `rx_data[8k+7:8k]` = `mem[rptr+k]` for k < occupancy, else 0.
- **`tx_packet_data`:** equals `mem[rptr]` when occupancy > 0, else 0.
- **Per-cycle operations:** at most one push and one pop per cycle.
  - Push sources: AHB store (n = size bytes) or RX store (n = 1). If both assert, AHB wins; the RX byte is dropped and `overflow_err` is raised.
  - Pop sources: AHB get (n = size bytes) or TX get (n = 1). If both assert, AHB wins; the TX request is dropped and `underflow_err` is raised.
- **Acceptance:**
  - A push is accepted only if occupancy + n ≤ `DEPTH`, judged on the pre-cycle occupancy (ignores a same-cycle pop).
  - A pop is accepted only if n ≤ pre-cycle occupancy (ignores a same-cycle push).
  - A rejected request is all-or-nothing: no partial bytes, pointers unchanged, and the matching error pulses.
- **Update:**
  - Accepted push: writes n bytes at `wptr`..`wptr`+n-1 (wrapping) and advances `wptr` by n.
  - Accepted pop: advances `rptr` by n.
  - Next occupancy = occupancy + n_push − n_pop.
- **`data_size` = 11:** ignored entirely; no error from this block, since upstream has already returned ERROR.
- **`clear`:** highest priority. Pointers and occupancy go to 0; all other requests in that cycle are discarded without error.

## Timing
- **Reset** (async, nRst low): `wptr` = `rptr` = 0, occupancy = 0, both error outputs 0. Memory contents are not reset. `rx_data` and `tx_packet_data` read 0 because they are masked by occupancy.
- **Outputs:**
  - `rx_data` and `tx_packet_data` are combinational from registered state, so they are valid in the same cycle as the pop request.
  - `buffer_occupancy` is registered and updates on the edge that commits the request.
  - Error pulses are registered, high for exactly the cycle after the offending request.
- **Latency:** a pushed byte is visible at the head the cycle after the push edge; there is no bypass.
- **Full:** with occupancy = `DEPTH` and a simultaneous 1-byte push and 1-byte pop, the push is rejected and the pop is accepted.
- **Empty:** with occupancy = 0 and a simultaneous push and pop, the pop is rejected and the push is accepted.
- **Wrap:** a 4-byte push at `wptr` = `DEPTH`-2 writes locations `DEPTH`-2, `DEPTH`-1, 0, 1.
- **Reset mid-operation:** drops all state immediately, with no completion of the in-flight transfer.

## Structure
- **Shared package `usb_ahb_pkg`:**
  - `hsize` encodings: SIZE_BYTE=00, SIZE_HALF=01, SIZE_WORD=10.
  - `BUFFER_DEPTH`=64.
  - Function `size_to_bytes(hsize)`, returning 0 for 11.
- **Sub-modules:** none. Memory, pointers, arbitration and occupancy stay in `data_buffer`; estimated 150–250 lines.

## Test plan
- **Reset and basic word write/read:** reset → occupancy 0, rx_data 0. Push word 0xDDCCBBAA, then pop a word → rx_data 0xDDCCBBAA in the pop cycle, occupancy 4→0.
- **Byte serialization to TX:** push word 0x44332211, then 4 TX pops → tx_packet_data 0x11, 0x22, 0x33, 0x44; occupancy 3, 2, 1, 0.
- **Overflow at full:** fill 64 bytes with sequential values, then push a word → overflow_err pulses once, occupancy stays 64, contents unchanged.
- **Underflow and wrap:** with occupancy 2, a word pop → underflow_err, no pointer change. Advance pointers to 62, push 0xA4A3A2A1 → a word pop returns it intact across the wrap.
- **Simultaneous events:** AHB push and RX push in the same cycle → AHB bytes stored, overflow_err pulse. With occupancy 64, a 1-byte push plus 1-byte pop → occupancy 63.
- **Clear and size 11:** clear alongside a word push → occupancy 0, no error. A size-11 store → no change, no error.
